vga_roi_overlay: RTL

//  Downstream stage of the VGA timing generator. Consumes the sync/de pixel stream plus

---
 rtl/vga_roi_overlay.sv | 135 +++++++++++++
 1 files changed

// File: rtl/vga_roi_overlay.sv
// Two-stage overlay on the VGA pixel stream: draws a rectangular outline of BOX_RGB
// whose coordinates are shadowed and only take effect at the next frame start.
module vga_roi_overlay #(
  parameter logic        HS_POL  = 1'b0,
  parameter logic        VS_POL  = 1'b0,
  parameter logic [11:0] THICK   = 12'd2,
  parameter logic [23:0] BOX_RGB = 24'hFF0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_hs,
  input  logic        in_vs,
  input  logic        in_de,
  input  logic [23:0] in_rgb,
  input  logic [11:0] roi_x0,
  input  logic [11:0] roi_x1,
  input  logic [11:0] roi_y0,
  input  logic [11:0] roi_y1,
  input  logic        roi_wr,
  input  logic        box_en,
  output logic        out_hs,
  output logic        out_vs,
  output logic        out_de,
  output logic [23:0] out_rgb,
  output logic        frame_start
);

  localparam logic [12:0] THICK13 = {1'b0, THICK};

  logic        vs_prev_q, de_prev_q;
  logic [11:0] sh_x0_q, sh_x1_q, sh_y0_q, sh_y1_q;
  logic [11:0] act_x0_q, act_x1_q, act_y0_q, act_y1_q;
  logic        act_en_q;
  logic [11:0] x_q, x_d, y_q, y_d;

  logic        s1_hs_q, s1_vs_q, s1_de_q, s1_hit_q, s1_fs_q;
  logic [23:0] s1_rgb_q;

  logic        fs;
  logic [12:0] x13, y13, ax0, ax1, ay0, ay1;
  logic        inx, iny, edge_l, edge_r, edge_t, edge_b, hit;

  assign fs = (in_vs == VS_POL) && (vs_prev_q != VS_POL);

  always_comb begin
    x_d = 12'd0;
    if (in_de) x_d = (x_q == 12'hFFF) ? x_q : x_q + 12'd1;
    y_d = y_q;
    if (fs) y_d = 12'd0;
    else if (de_prev_q && !in_de && (y_q != 12'hFFF)) y_d = y_q + 12'd1;
  end

  // 13-bit compares so x0+THICK and x+THICK never wrap at the 4095 boundary
  always_comb begin
    x13    = {1'b0, x_q};
    y13    = {1'b0, y_q};
    ax0    = {1'b0, act_x0_q};
    ax1    = {1'b0, act_x1_q};
    ay0    = {1'b0, act_y0_q};
    ay1    = {1'b0, act_y1_q};
    inx    = (x13 >= ax0) && (x13 <= ax1);
    iny    = (y13 >= ay0) && (y13 <= ay1);
    edge_l = x13 < (ax0 + THICK13);
    edge_r = (x13 + THICK13) > ax1;
    edge_t = y13 < (ay0 + THICK13);
    edge_b = (y13 + THICK13) > ay1;
    hit    = act_en_q && in_de && inx && iny && (edge_l || edge_r || edge_t || edge_b);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vs_prev_q <= ~VS_POL;
      de_prev_q <= 1'b0;
      sh_x0_q   <= 12'd0;
      sh_x1_q   <= 12'd0;
      sh_y0_q   <= 12'd0;
      sh_y1_q   <= 12'd0;
      act_x0_q  <= 12'd0;
      act_x1_q  <= 12'd0;
      act_y0_q  <= 12'd0;
      act_y1_q  <= 12'd0;
      act_en_q  <= 1'b0;
      x_q       <= 12'd0;
      y_q       <= 12'd0;
    end else begin
      vs_prev_q <= in_vs;
      de_prev_q <= in_de;
      x_q       <= x_d;
      y_q       <= y_d;
      // Active set loads the old shadow, so a write on the fs cycle waits a frame
      if (fs) begin
        act_x0_q <= sh_x0_q;
        act_x1_q <= sh_x1_q;
        act_y0_q <= sh_y0_q;
        act_y1_q <= sh_y1_q;
        act_en_q <= box_en;
      end
      if (roi_wr) begin
        sh_x0_q <= roi_x0;
        sh_x1_q <= roi_x1;
        sh_y0_q <= roi_y0;
        sh_y1_q <= roi_y1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_hs_q     <= ~HS_POL;
      s1_vs_q     <= ~VS_POL;
      s1_de_q     <= 1'b0;
      s1_rgb_q    <= 24'd0;
      s1_hit_q    <= 1'b0;
      s1_fs_q     <= 1'b0;
      out_hs      <= ~HS_POL;
      out_vs      <= ~VS_POL;
      out_de      <= 1'b0;
      out_rgb     <= 24'd0;
      frame_start <= 1'b0;
    end else begin
      s1_hs_q     <= in_hs;
      s1_vs_q     <= in_vs;
      s1_de_q     <= in_de;
      s1_rgb_q    <= in_rgb;
      s1_hit_q    <= hit;
      s1_fs_q     <= fs;
      out_hs      <= s1_hs_q;
      out_vs      <= s1_vs_q;
      out_de      <= s1_de_q;
      out_rgb     <= s1_hit_q ? BOX_RGB : (s1_de_q ? s1_rgb_q : 24'd0);
      frame_start <= s1_fs_q;
    end
  end

endmodule
